// File: rtl/req_gnt_checker.sv
// Multi-channel request/grant latency checker: each channel must see gnt within
// [MIN_LAT, MAX_LAT] cycles of a starting req. Optional REQ_GNT_CHK_SPURIOUS_EN adds err_spur.

module req_gnt_chan #(
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic dis,
    input  logic req,
    input  logic gnt,
    output logic busy,
    output logic pass,
    output logic fail_early,
    output logic fail_tmo
);
    localparam int KW = $clog2(MAX_LAT + 1);
    localparam logic [KW-1:0] MIN_K = KW'(MIN_LAT);
    localparam logic [KW-1:0] MAX_K = KW'(MAX_LAT);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] j;
    logic          done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // j is the req->gnt distance being judged at this edge
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        pass       = 1'b0;
        fail_early = 1'b0;
        fail_tmo   = 1'b0;
        done       = 1'b0;
        j          = k_q + 1'b1;
        if (dis) begin
            state_d = IDLE;
            k_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_d = WAIT;
                        k_d     = '0;
                    end
                end
                WAIT: begin
                    if (gnt) begin
                        done = 1'b1;
                        if (j < MIN_K) fail_early = 1'b1;
                        else           pass       = 1'b1;
                    end else if (j == MAX_K) begin
                        done     = 1'b1;
                        fail_tmo = 1'b1;
                    end
                    if (done) begin
                        state_d = req ? WAIT : IDLE;
                        k_d     = '0;
                    end else begin
                        k_d = j;
                    end
                end
                default: begin
                    state_d = IDLE;
                    k_d     = '0;
                end
            endcase
        end
    end

    assign busy = (state_q == WAIT);
endmodule

module req_gnt_checker #(
    parameter int NUM_CH  = 4,
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dis,
    input  logic              clear,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] gnt,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] err_pulse,
    output logic [NUM_CH-1:0] err_early,
    output logic [NUM_CH-1:0] err_tmo,
`ifdef REQ_GNT_CHK_SPURIOUS_EN
    output logic [NUM_CH-1:0] err_spur,
`endif
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);
    localparam int SW = CNT_W + 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] pass_v, early_v, tmo_v, spur_v, fail_v;
    logic [NUM_CH-1:0] err_pulse_q, err_pulse_d;
    logic [NUM_CH-1:0] err_early_q, err_early_d;
    logic [NUM_CH-1:0] err_tmo_q, err_tmo_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic [5:0]        n_pass, n_fail;
    logic [SW-1:0]     pass_sum, fail_sum;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        req_gnt_chan #(
            .MIN_LAT (MIN_LAT),
            .MAX_LAT (MAX_LAT)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .dis        (dis),
            .req        (req[i]),
            .gnt        (gnt[i]),
            .busy       (busy[i]),
            .pass       (pass_v[i]),
            .fail_early (early_v[i]),
            .fail_tmo   (tmo_v[i])
        );
    end

`ifdef REQ_GNT_CHK_SPURIOUS_EN
    logic [NUM_CH-1:0] err_spur_q, err_spur_d;

    // a grant alongside a starting req is distance 0, not spurious
    assign spur_v = dis ? '0 : (gnt & ~busy & ~req);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_spur_q <= '0;
        else          err_spur_q <= err_spur_d;
    end

    always_comb begin
        err_spur_d = clear ? '0 : (err_spur_q | spur_v);
    end

    assign err_spur = err_spur_q;
`else
    assign spur_v = '0;
`endif

    assign fail_v = early_v | tmo_v | spur_v;

    always_comb begin
        n_pass = '0;
        n_fail = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n_pass = n_pass + 6'(pass_v[i]);
            n_fail = n_fail + 6'(fail_v[i]);
        end
        pass_sum = SW'(pass_cnt_q) + SW'(n_pass);
        fail_sum = SW'(fail_cnt_q) + SW'(n_fail);

        err_pulse_d = fail_v;
        err_early_d = err_early_q | early_v;
        err_tmo_d   = err_tmo_q | tmo_v;
        pass_cnt_d  = (pass_sum > SW'(CNT_MAX)) ? CNT_MAX : pass_sum[CNT_W-1:0];
        fail_cnt_d  = (fail_sum > SW'(CNT_MAX)) ? CNT_MAX : fail_sum[CNT_W-1:0];
        // clear beats a coincident event for counters and flags, not for the pulse
        if (clear) begin
            err_early_d = '0;
            err_tmo_d   = '0;
            pass_cnt_d  = '0;
            fail_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_pulse_q <= '0;
            err_early_q <= '0;
            err_tmo_q   <= '0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
        end else begin
            err_pulse_q <= err_pulse_d;
            err_early_q <= err_early_d;
            err_tmo_q   <= err_tmo_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_early = err_early_q;
    assign err_tmo   = err_tmo_q;
    assign pass_cnt  = pass_cnt_q;
    assign fail_cnt  = fail_cnt_q;
endmodule

// File: tb/tb_req_gnt_checker.sv
// Directed bench for req_gnt_checker with NUM_CH=2, MIN_LAT=2, MAX_LAT=4, CNT_W=4.
// Expectations follow REQ_GNT_CHK_SPURIOUS_EN when it is defined.

module tb_req_gnt_checker;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              dis = 1'b0;
    logic              clear = 1'b0;
    logic [NUM_CH-1:0] req = '0;
    logic [NUM_CH-1:0] gnt = '0;
    logic [NUM_CH-1:0] busy, err_pulse, err_early, err_tmo;
`ifdef REQ_GNT_CHK_SPURIOUS_EN
    logic [NUM_CH-1:0] err_spur;
`endif
    logic [CNT_W-1:0]  pass_cnt, fail_cnt;

    int n_chk = 0;
    int n_err = 0;

    req_gnt_checker #(
        .NUM_CH  (NUM_CH),
        .MIN_LAT (2),
        .MAX_LAT (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dis       (dis),
        .clear     (clear),
        .req       (req),
        .gnt       (gnt),
        .busy      (busy),
        .err_pulse (err_pulse),
        .err_early (err_early),
        .err_tmo   (err_tmo),
`ifdef REQ_GNT_CHK_SPURIOUS_EN
        .err_spur  (err_spur),
`endif
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pulse", 32'(err_pulse), 0);
        chk("rst_early", 32'(err_early), 0);
        chk("rst_tmo", 32'(err_tmo), 0);
        chk("rst_pass", 32'(pass_cnt), 0);
        chk("rst_fail", 32'(fail_cnt), 0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // pass at distance 3
        req = 2'b01; tick(); req = 2'b00;
        chk("p_busy1", 32'(busy), 1);
        tick(); chk("p_busy2", 32'(busy), 1);
        tick(); chk("p_busy3", 32'(busy), 1);
        chk("p_nopulse", 32'(err_pulse), 0);
        gnt = 2'b01; tick(); gnt = 2'b00;
        chk("p_busy_done", 32'(busy), 0);
        chk("p_pass_cnt", 32'(pass_cnt), 1);
        chk("p_pulse", 32'(err_pulse), 0);
        chk("p_fail_cnt", 32'(fail_cnt), 0);

        // early grant at distance 1
        req = 2'b01; tick(); req = 2'b00;
        gnt = 2'b01; tick(); gnt = 2'b00;
        chk("e_pulse", 32'(err_pulse), 1);
        chk("e_early", 32'(err_early), 1);
        chk("e_fail_cnt", 32'(fail_cnt), 1);
        tick();
        chk("e_pulse_end", 32'(err_pulse), 0);
        chk("e_early_sticky", 32'(err_early), 1);

        // clear coinciding with an early failure
        req = 2'b01; tick(); req = 2'b00;
        gnt = 2'b01; clear = 1'b1; tick(); gnt = 2'b00; clear = 1'b0;
        chk("c_pulse", 32'(err_pulse), 1);
        chk("c_early", 32'(err_early), 0);
        chk("c_fail_cnt", 32'(fail_cnt), 0);
        chk("c_pass_cnt", 32'(pass_cnt), 0);

        // ch1 timeout at distance 4
        req = 2'b10; tick(); req = 2'b00;
        repeat (3) tick();
        chk("t_pre_pulse", 32'(err_pulse), 0);
        chk("t_pre_busy", 32'(busy), 2);
        tick();
        chk("t_pulse", 32'(err_pulse), 2);
        chk("t_tmo", 32'(err_tmo), 2);
        chk("t_busy", 32'(busy), 0);
        chk("t_fail_cnt", 32'(fail_cnt), 1);

        // dual timeouts and saturation
        do_clear();
        req = 2'b11; tick(); req = 2'b00;
        repeat (3) tick();
        chk("d_fail_pre", 32'(fail_cnt), 0);
        tick();
        chk("d_fail_2", 32'(fail_cnt), 2);
        chk("d_pulse", 32'(err_pulse), 3);
        for (int r = 0; r < 8; r++) begin
            req = 2'b11; tick(); req = 2'b00;
            repeat (4) tick();
            if (r == 0) chk("d_fail_4", 32'(fail_cnt), 4);
            if (r == 5) chk("d_fail_14", 32'(fail_cnt), 14);
        end
        chk("d_fail_sat", 32'(fail_cnt), 15);

        // disable aborts an attempt; later gnt in IDLE
        do_clear();
        req = 2'b01; tick(); req = 2'b00;
        dis = 1'b1; tick();
        chk("x_busy", 32'(busy), 0);
        tick(); dis = 1'b0;
        repeat (2) tick();
        gnt = 2'b01; tick(); gnt = 2'b00;
        chk("x_pass_cnt", 32'(pass_cnt), 0);
`ifdef REQ_GNT_CHK_SPURIOUS_EN
        chk("x_spur", 32'(err_spur), 1);
        chk("x_fail_cnt", 32'(fail_cnt), 1);
        chk("x_pulse", 32'(err_pulse), 1);
`else
        chk("x_fail_cnt", 32'(fail_cnt), 0);
        chk("x_pulse", 32'(err_pulse), 0);
`endif

        // continuous req with re-arm passes at distance 3
        do_clear();
        req = 2'b01; tick();
        for (int n = 1; n <= 4; n++) begin
            tick(); chk("r_busy_a", 32'(busy), 1);
            tick(); chk("r_busy_b", 32'(busy), 1);
            gnt = 2'b01; tick(); gnt = 2'b00;
            chk("r_busy_c", 32'(busy), 1);
            chk("r_pass_cnt", 32'(pass_cnt), 32'(n));
            chk("r_pulse", 32'(err_pulse), 0);
        end
        chk("r_fail_cnt", 32'(fail_cnt), 0);

        // async reset mid-attempt
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("a_busy", 32'(busy), 0);
        chk("a_pass_cnt", 32'(pass_cnt), 0);
        chk("a_pulse", 32'(err_pulse), 0);
        req = 2'b00;
        tick();
        reset_n = 1'b1;
        tick();
        chk("a_busy_after", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
